// File: rtl/edge_bbox_pkg.sv
// Shared edge-frame types for the Sobel stage and the bounding-box scanner.
// Purely declarative: no timing, no flow control.
package edge_bbox_pkg;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int EDGE_ADDR_W  = 19;
    localparam int EDGE_DATA_W  = 4;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;

    typedef logic [X_W-1:0]         x_t;
    typedef logic [Y_W-1:0]         y_t;
    typedef logic [EDGE_DATA_W-1:0] edge_t;

    typedef struct packed {
        logic vld;
        x_t   x;
        y_t   y;
    } tag_t;

    // Border pixels are never written by the Sobel stage and hold stale data.
    function automatic logic is_interior(input x_t x, input y_t y,
                                         input x_t x_last, input y_t y_last);
        return (x != '0) && (x != x_last) && (y != '0) && (y != y_last);
    endfunction

endpackage

// File: rtl/edge_bbox_if.sv
// Control, BRAM read port and result bus of the bounding-box scanner.
// Latency: none (wires only); backpressure: none, the scanner paces the BRAM.
interface edge_bbox_if
    import edge_bbox_pkg::*;
#(
    parameter int ADDR_W = EDGE_ADDR_W
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] edge_memory_addr;
    edge_t             edge_data;
    x_t                x_min;
    x_t                x_max;
    y_t                y_min;
    y_t                y_max;
    logic [ADDR_W-1:0] edge_count;
    logic              bbox_valid;

    modport master (
        output start, edge_data,
        input  busy, done, edge_memory_addr,
        input  x_min, x_max, y_min, y_max, edge_count, bbox_valid
    );

    modport slave (
        input  start, edge_data,
        output busy, done, edge_memory_addr,
        output x_min, x_max, y_min, y_max, edge_count, bbox_valid
    );

endinterface

// File: rtl/edge_bbox_acc.sv
// Edge-pixel population count and running min/max per axis.
// Latency: 1 cycle per sample; backpressure: none, accepts a sample every cycle.
module edge_bbox_acc
    import edge_bbox_pkg::*;
#(
    parameter int CNT_W = EDGE_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic             is_edge,
    input  x_t               x,
    input  y_t               y,
    output logic [CNT_W-1:0] count,
    output x_t               x_min,
    output x_t               x_max,
    output y_t               y_min,
    output y_t               y_max
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    x_t               x_min_q, x_min_d, x_max_q, x_max_d;
    y_t               y_min_q, y_min_d, y_max_q, y_max_d;

    always_comb begin
        cnt_d   = cnt_q;
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_min_d = y_min_q;
        y_max_d = y_max_q;
        if (clear) begin
            cnt_d   = '0;
            x_min_d = '0;
            x_max_d = '0;
            y_min_d = '0;
            y_max_d = '0;
        end else if (sample_valid && is_edge) begin
            cnt_d = cnt_q + 1'b1;
            // An empty box has no meaningful extent, so the first edge seeds both bounds.
            if (cnt_q == '0) begin
                x_min_d = x;
                x_max_d = x;
                y_min_d = y;
                y_max_d = y;
            end else begin
                if (x < x_min_q) x_min_d = x;
                if (x > x_max_q) x_max_d = x;
                if (y < y_min_q) y_min_d = y;
                if (y > y_max_q) y_max_d = y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
        end
    end

    assign count = cnt_q;
    assign x_min = x_min_q;
    assign x_max = x_max_q;
    assign y_min = y_min_q;
    assign y_max = y_max_q;

endmodule

// File: rtl/edge_bbox.sv
// Raster scan of the edge BRAM producing one bounding box and edge count per frame.
// Latency: WIDTH*HEIGHT + READ_LATENCY + 1 cycles start-to-done; backpressure: none, start ignored while busy.
module edge_bbox
    import edge_bbox_pkg::*;
#(
    parameter int WIDTH        = FRAME_WIDTH,
    parameter int HEIGHT       = FRAME_HEIGHT,
    parameter int ADDR_W       = EDGE_ADDR_W,
    parameter int READ_LATENCY = 2,
    parameter int MIN_COUNT    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    edge_bbox_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam x_t                X_LAST    = x_t'(WIDTH - 1);
    localparam y_t                Y_LAST    = y_t'(HEIGHT - 1);
    localparam int                DRN_W     = $clog2(READ_LATENCY + 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(READ_LATENCY - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    x_t                x_q, x_d;
    y_t                y_q, y_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    tag_t              tag_q [READ_LATENCY];
    tag_t              tag_d [READ_LATENCY];
    tag_t              new_tag;
    tag_t              tag_out;
    logic              acc_clear;

    x_t                x_min_q, x_min_d, x_max_q, x_max_d;
    y_t                y_min_q, y_min_d, y_max_q, y_max_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] acc_count;
    x_t                acc_x_min, acc_x_max;
    y_t                acc_y_min, acc_y_max;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        x_d       = x_q;
        y_d       = y_q;
        drn_d     = drn_q;
        acc_clear = 1'b0;
        new_tag   = '0;
        x_min_d   = x_min_q;
        x_max_d   = x_max_q;
        y_min_d   = y_min_q;
        y_max_d   = y_max_q;
        count_d   = count_q;
        valid_d   = valid_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_SCAN;
                    addr_d    = '0;
                    x_d       = '0;
                    y_d       = '0;
                    drn_d     = '0;
                    acc_clear = 1'b1;
                end
            end
            S_SCAN: begin
                new_tag.vld = 1'b1;
                new_tag.x   = x_q;
                new_tag.y   = y_q;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    drn_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) state_d = S_FINISH;
                else                   drn_d   = drn_q + 1'b1;
            end
            S_FINISH: begin
                state_d = S_DONE;
                x_min_d = acc_x_min;
                x_max_d = acc_x_max;
                y_min_d = acc_y_min;
                y_max_d = acc_y_max;
                count_d = acc_count;
                valid_d = (acc_count >= ADDR_W'(MIN_COUNT));
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Each tag travels alongside its address so it meets the matching BRAM word.
    always_comb begin
        tag_d[0] = new_tag;
        for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    assign tag_out = tag_q[READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drn_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drn_q   <= drn_d;
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= tag_d[i];
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    edge_bbox_acc #(
        .CNT_W (ADDR_W)
    ) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (acc_clear),
        .sample_valid (tag_out.vld && is_interior(tag_out.x, tag_out.y, X_LAST, Y_LAST)),
        .is_edge      (|bus.edge_data),
        .x            (tag_out.x),
        .y            (tag_out.y),
        .count        (acc_count),
        .x_min        (acc_x_min),
        .x_max        (acc_x_max),
        .y_min        (acc_y_min),
        .y_max        (acc_y_max)
    );

    assign bus.busy             = (state_q == S_SCAN) || (state_q == S_DRAIN) || (state_q == S_FINISH);
    assign bus.done             = (state_q == S_DONE);
    assign bus.edge_memory_addr = addr_q;
    assign bus.x_min            = x_min_q;
    assign bus.x_max            = x_max_q;
    assign bus.y_min            = y_min_q;
    assign bus.y_max            = y_max_q;
    assign bus.edge_count       = count_q;
    assign bus.bbox_valid       = valid_q;

endmodule

// File: tb/tb_edge_bbox.sv
// Three scanners on an 8x6 frame with read latencies 1, 2 and 3 share one
// behavioural edge memory and one start/reset; directed frames with hand-computed boxes.
module tb_edge_bbox;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 6;

    logic clk;
    logic rst_n;
    logic start;
    int   cyc;

    logic [3:0] mem [64];

    logic [2:0]          busy_v, done_v, valid_v;
    logic [2:0][AW-1:0]  addr_v, cnt_v;
    logic [2:0][9:0]     xmn_v, xmx_v;
    logic [2:0][8:0]     ymn_v, ymx_v;

    int n_vec;
    int n_err;
    int lat [3];
    int exp_lat [3] = '{50, 51, 52};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RL = g + 1;

        edge_bbox_if #(.ADDR_W(AW)) bus ();

        logic [3:0] rd_pipe [RL];

        always @(posedge clk) begin
            rd_pipe[0] <= mem[bus.edge_memory_addr];
            for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        end

        assign bus.start     = start;
        assign bus.edge_data = rd_pipe[RL-1];

        edge_bbox #(
            .WIDTH        (W),
            .HEIGHT       (H),
            .ADDR_W       (AW),
            .READ_LATENCY (RL),
            .MIN_COUNT    (2)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign valid_v[g] = bus.bbox_valid;
        assign addr_v[g]  = bus.edge_memory_addr;
        assign cnt_v[g]   = bus.edge_count;
        assign xmn_v[g]   = bus.x_min;
        assign xmx_v[g]   = bus.x_max;
        assign ymn_v[g]   = bus.y_min;
        assign ymx_v[g]   = bus.y_max;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    endtask

    task automatic set_px(input int x, input int y, input logic [3:0] v);
        mem[y * W + x] = v;
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_addr%0d", tag, g),  addr_v[g], 0);
            chk($sformatf("%s_busy%0d", tag, g),  busy_v[g], 0);
            chk($sformatf("%s_done%0d", tag, g),  done_v[g], 0);
            chk($sformatf("%s_cnt%0d", tag, g),   cnt_v[g], 0);
            chk($sformatf("%s_xmin%0d", tag, g),  xmn_v[g], 0);
            chk($sformatf("%s_xmax%0d", tag, g),  xmx_v[g], 0);
            chk($sformatf("%s_ymin%0d", tag, g),  ymn_v[g], 0);
            chk($sformatf("%s_ymax%0d", tag, g),  ymx_v[g], 0);
            chk($sformatf("%s_valid%0d", tag, g), valid_v[g], 0);
        end
    endtask

    task automatic chk_frame(input string tag, input int xmn, input int xmx,
                             input int ymn, input int ymx, input int cnt, input int vld);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_xmin_rl%0d", tag, g + 1),  xmn_v[g], xmn);
            chk($sformatf("%s_xmax_rl%0d", tag, g + 1),  xmx_v[g], xmx);
            chk($sformatf("%s_ymin_rl%0d", tag, g + 1),  ymn_v[g], ymn);
            chk($sformatf("%s_ymax_rl%0d", tag, g + 1),  ymx_v[g], ymx);
            chk($sformatf("%s_cnt_rl%0d", tag, g + 1),   cnt_v[g], cnt);
            chk($sformatf("%s_valid_rl%0d", tag, g + 1), valid_v[g], vld);
        end
    endtask

    task automatic chk_lat(input string tag);
        for (int g = 0; g < 3; g++)
            chk($sformatf("%s_done_lat_rl%0d", tag, g + 1), lat[g], exp_lat[g]);
    endtask

    // One scan from start; pulse_at >= 0 re-asserts start for one cycle mid-scan.
    task automatic run_scan(input string tag, input int pulse_at);
        int  k;
        int  n;
        bit  all_seen;
        for (int g = 0; g < 3; g++) lat[g] = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = cyc;
        chk({tag, "_busy_after_start"}, busy_v, 3'b111);
        chk({tag, "_done_after_start"}, done_v, 3'b000);
        n = 0;
        all_seen = 1'b0;
        while (!all_seen && n < 200) begin
            @(negedge clk);
            n++;
            start = ((cyc - k) == pulse_at);
            for (int g = 0; g < 3; g++)
                if (lat[g] < 0 && done_v[g]) lat[g] = cyc - k;
            all_seen = (lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0);
        end
        start = 1'b0;
        chk({tag, "_scan_completed"}, all_seen, 1);
        chk({tag, "_busy_after_done"}, busy_v, 3'b000);
    endtask

    task automatic wait_all_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_v != 3'b111 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_all_done"}, done_v, 3'b111);
    endtask

    task automatic held_start_test();
        bit dn [3];
        bit rb [3];
        int dc [3];
        int rc [3];
        int n;
        bit all_rb;
        for (int g = 0; g < 3; g++) begin
            dn[g] = 1'b0;
            rb[g] = 1'b0;
            dc[g] = 0;
            rc[g] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        n = 0;
        all_rb = 1'b0;
        while (!all_rb && n < 300) begin
            @(negedge clk);
            n++;
            for (int g = 0; g < 3; g++) begin
                if (!dn[g]) begin
                    if (done_v[g]) begin
                        dn[g] = 1'b1;
                        dc[g] = cyc;
                    end
                end else if (!rb[g] && busy_v[g]) begin
                    rb[g] = 1'b1;
                    rc[g] = cyc;
                end
            end
            all_rb = rb[0] && rb[1] && rb[2];
        end
        start = 1'b0;
        chk("held_all_restarted", all_rb, 1);
        for (int g = 0; g < 3; g++)
            chk($sformatf("held_restart_gap_rl%0d", g + 1), rc[g] - dc[g], 1);
        chk("held_busy_second_scan", busy_v, 3'b111);
        chk_frame("held_during", 1, 6, 1, 4, 3, 1);
        wait_all_done("held", 300);
        chk_frame("held_after", 1, 6, 1, 4, 3, 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        start = 1'b0;
        rst_n = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Empty frame.
        run_scan("empty", -1);
        chk_lat("empty");
        chk_frame("empty", 0, 0, 0, 0, 0, 0);
        chk("empty_done_held", done_v, 3'b111);

        // Two edges; count equals MIN_COUNT so the box is valid.
        set_px(2, 1, 4'h1);
        set_px(5, 4, 4'h8);
        run_scan("two", -1);
        chk_lat("two");
        chk_frame("two", 2, 5, 1, 4, 2, 1);

        // Stale border data must be ignored; one interior edge is below MIN_COUNT.
        clear_mem();
        for (int x = 0; x < W; x++) begin
            set_px(x, 0, 4'hF);
            set_px(x, H - 1, 4'hF);
        end
        for (int y = 0; y < H; y++) begin
            set_px(0, y, 4'hF);
            set_px(W - 1, y, 4'hF);
        end
        set_px(3, 3, 4'h2);
        run_scan("border", -1);
        chk_lat("border");
        chk_frame("border", 3, 3, 3, 3, 1, 0);

        // Min updated by a later edge; a start pulse while busy must not disturb timing.
        clear_mem();
        set_px(4, 1, 4'h3);
        set_px(1, 2, 4'h1);
        set_px(6, 4, 4'h5);
        run_scan("pulse", 10);
        chk_lat("pulse");
        chk_frame("pulse", 1, 6, 1, 4, 3, 1);

        // Reset in the middle of a scan, then a clean scan of a different frame.
        clear_mem();
        set_px(2, 1, 4'h1);
        set_px(5, 4, 4'h8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midscan_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_scan("after_rst", -1);
        chk_lat("after_rst");
        chk_frame("after_rst", 2, 5, 1, 4, 2, 1);

        // Start held high through DONE.
        clear_mem();
        set_px(4, 1, 4'h3);
        set_px(1, 2, 4'h1);
        set_px(6, 4, 4'h5);
        held_start_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
